// File: rtl/gshare_bpred_if.sv
// Fetch/decode-side signal bundle for the gshare branch predictor.
// The core side is master and drives lookups and training. The predictor is slave.
interface gshare_bpred_if #(
  parameter int unsigned HIST_LEN = 8
);
  logic [31:0]         pcF;
  logic                lookupF;
  logic                BpredF;
  logic [HIST_LEN-1:0] ghr_snapF;
  logic                readyF;
  logic [31:0]         pcD;
  logic                BpredWriteD;
  logic                br_takenD;
  logic [HIST_LEN-1:0] ghr_snapD;
  logic                mispredictD;
  logic [31:0]         mispred_cnt;

  modport master (
    output pcF, lookupF, pcD, BpredWriteD, br_takenD, ghr_snapD, mispredictD,
    input  BpredF, ghr_snapF, readyF, mispred_cnt
  );

  modport slave (
    input  pcF, lookupF, pcD, BpredWriteD, br_takenD, ghr_snapD, mispredictD,
    output BpredF, ghr_snapF, readyF, mispred_cnt
  );
endinterface

// File: rtl/gshare_bpred.sv
// Gshare / bimodal conditional branch predictor for the fetch stage.
// The table of saturating counters has no reset. After reset a sequential
// init walk sets every entry to weakly taken, so the table can map onto RAM.
module gshare_bpred #(
  parameter int unsigned INDEX_SIZE = 10,
  parameter int unsigned HIST_LEN   = 8,
  parameter int unsigned CTR_W      = 2,
  parameter int unsigned GSHARE     = 1
) (
  input logic           clk,
  input logic           reset,
  gshare_bpred_if.slave bp
);

  localparam int unsigned ENTRIES = 1 << INDEX_SIZE;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [CTR_W-1:0]      CTR_WEAK = {1'b1, {(CTR_W-1){1'b0}}};
  localparam logic [CTR_W-1:0]      CTR_MAX  = '1;
  localparam logic [CTR_W-1:0]      CTR_ZERO = '0;
  localparam logic [CTR_W-1:0]      CTR_ONE  = CTR_W'(1);
  localparam logic [INDEX_SIZE-1:0] PTR_LAST = '1;
  localparam logic [INDEX_SIZE-1:0] PTR_ONE  = INDEX_SIZE'(1);

  logic [CTR_W-1:0]      r_table [ENTRIES];
  logic [0:0]            r_state;
  logic [INDEX_SIZE-1:0] r_init_ptr;
  logic [HIST_LEN-1:0]   r_ghr;
  logic [31:0]           r_mispred_cnt;

  logic                  w_run;
  logic                  w_mispred;
  logic                  w_bpred;
  logic [INDEX_SIZE-1:0] w_hist_f;
  logic [INDEX_SIZE-1:0] w_hist_d;
  logic [INDEX_SIZE-1:0] w_idx_f;
  logic [INDEX_SIZE-1:0] w_idx_d;
  logic [CTR_W-1:0]      w_ctr_f;
  logic [CTR_W-1:0]      w_ctr_d;
  logic [CTR_W-1:0]      w_ctr_upd;
  logic                  w_wr_en;
  logic [INDEX_SIZE-1:0] w_wr_idx;
  logic [CTR_W-1:0]      w_wr_data;
  logic [HIST_LEN-1:0]   w_ghr_repair;
  logic [HIST_LEN-1:0]   w_ghr_shift;
  logic [35-INDEX_SIZE:0] w_unused_pc;

  assign w_run     = (r_state == ST_RUN);
  assign w_mispred = bp.BpredWriteD & bp.mispredictD;

  // Only the word-aligned index bits of each PC feed the table.
  assign w_unused_pc = {bp.pcF[31:INDEX_SIZE+2], bp.pcF[1:0],
                        bp.pcD[31:INDEX_SIZE+2], bp.pcD[1:0]};

  // Index formation: PC word bits, optionally XORed with zero-extended history.
  always_comb begin
    w_hist_f = INDEX_SIZE'(r_ghr);
    w_hist_d = INDEX_SIZE'(bp.ghr_snapD);
    w_idx_f  = bp.pcF[INDEX_SIZE+1:2] ^ ((GSHARE != 0) ? w_hist_f : '0);
    w_idx_d  = bp.pcD[INDEX_SIZE+1:2] ^ ((GSHARE != 0) ? w_hist_d : '0);
  end

  // Zero-latency read for fetch and read-modify for training.
  always_comb begin
    w_ctr_f = r_table[w_idx_f];
    w_ctr_d = r_table[w_idx_d];
    w_bpred = w_run & w_ctr_f[CTR_W-1];
  end

  // Saturating counter update for the resolving branch.
  always_comb begin
    w_ctr_upd = w_ctr_d;
    if (bp.br_takenD) begin
      if (w_ctr_d != CTR_MAX) w_ctr_upd = w_ctr_d + CTR_ONE;
    end else begin
      if (w_ctr_d != CTR_ZERO) w_ctr_upd = w_ctr_d - CTR_ONE;
    end
  end

  // Single table write port: the init walk owns it until RUN, then training does.
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_idx  = r_init_ptr;
    w_wr_data = CTR_WEAK;
    if (!w_run) begin
      w_wr_en = 1'b1;
    end else if (bp.BpredWriteD) begin
      w_wr_en   = 1'b1;
      w_wr_idx  = w_idx_d;
      w_wr_data = w_ctr_upd;
    end
  end

  // Next-history candidates. A one-bit history degenerates to the newest outcome.
  if (HIST_LEN == 1) begin : g_hist1
    assign w_ghr_repair = bp.br_takenD;
    assign w_ghr_shift  = w_bpred;
  end else begin : g_histn
    assign w_ghr_repair = {bp.ghr_snapD[HIST_LEN-2:0], bp.br_takenD};
    assign w_ghr_shift  = {r_ghr[HIST_LEN-2:0], w_bpred};
  end

  // Counter table storage, no reset so it can be a RAM.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_table[w_wr_idx] <= w_wr_data;
  end

  // Init walk sequencing: one entry per cycle, then switch to RUN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_INIT;
      r_init_ptr <= '0;
    end else if (r_state == ST_INIT) begin
      r_init_ptr <= r_init_ptr + PTR_ONE;
      if (r_init_ptr == PTR_LAST) r_state <= ST_RUN;
    end
  end

  // Speculative history: a mispredict repair overrides this cycle's fetch shift.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ghr <= '0;
    end else if (w_run) begin
      if (w_mispred)       r_ghr <= w_ghr_repair;
      else if (bp.lookupF) r_ghr <= w_ghr_shift;
    end
  end

  // Mispredict counter, free-running wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mispred_cnt <= '0;
    end else if (w_run && w_mispred) begin
      r_mispred_cnt <= r_mispred_cnt + 32'd1;
    end
  end

  assign bp.BpredF      = w_bpred;
  assign bp.ghr_snapF   = r_ghr;
  assign bp.readyF      = w_run;
  assign bp.mispred_cnt = r_mispred_cnt;

endmodule

// File: tb/tb_gshare_bpred.sv
// Scoreboard bench for gshare_bpred: one pure-bimodal and one gshare instance
// share the same stimulus. Expectations are queued with each stimulus step
// and checked by an independent monitor on the falling clock edge.
module tb_gshare_bpred;

  localparam int unsigned HL = 8;

  localparam int unsigned S_PRED = 0;
  localparam int unsigned S_GHR  = 1;
  localparam int unsigned S_RDY  = 2;
  localparam int unsigned S_CNT  = 3;
  localparam int unsigned D_BOTH = 2;

  // Training walk on pcD = 0x40: directions and counter MSBs, step i = bit i.
  localparam logic [7:0] T2_DIR = 8'b0111_1000;
  localparam logic [7:0] T2_OLD = 8'b1110_0001;
  localparam logic [7:0] T2_NEW = 8'b1111_0000;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   pcF;
  logic [31:0]   pcD;
  logic          lookupF;
  logic          BpredWriteD;
  logic          br_takenD;
  logic          mispredictD;
  logic [HL-1:0] ghr_snapD;

  typedef struct {
    string       name;
    int unsigned dut;
    int unsigned sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  gshare_bpred_if #(.HIST_LEN(HL)) if0 ();
  gshare_bpred_if #(.HIST_LEN(HL)) if1 ();

  assign if0.pcF = pcF;                 assign if1.pcF = pcF;
  assign if0.lookupF = lookupF;         assign if1.lookupF = lookupF;
  assign if0.pcD = pcD;                 assign if1.pcD = pcD;
  assign if0.BpredWriteD = BpredWriteD; assign if1.BpredWriteD = BpredWriteD;
  assign if0.br_takenD = br_takenD;     assign if1.br_takenD = br_takenD;
  assign if0.ghr_snapD = ghr_snapD;     assign if1.ghr_snapD = ghr_snapD;
  assign if0.mispredictD = mispredictD; assign if1.mispredictD = mispredictD;

  gshare_bpred #(.INDEX_SIZE(10), .HIST_LEN(HL), .CTR_W(2), .GSHARE(0)) dut0 (
    .clk(clk), .reset(reset), .bp(if0)
  );

  gshare_bpred #(.INDEX_SIZE(10), .HIST_LEN(HL), .CTR_W(2), .GSHARE(1)) dut1 (
    .clk(clk), .reset(reset), .bp(if1)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] actual(int unsigned d, int unsigned s);
    logic [31:0] v;
    v = '0;
    if (d == 0) begin
      case (s)
        S_PRED:  v = {31'd0, if0.BpredF};
        S_GHR:   v = 32'(if0.ghr_snapF);
        S_RDY:   v = {31'd0, if0.readyF};
        default: v = if0.mispred_cnt;
      endcase
    end else begin
      case (s)
        S_PRED:  v = {31'd0, if1.BpredF};
        S_GHR:   v = 32'(if1.ghr_snapF);
        S_RDY:   v = {31'd0, if1.readyF};
        default: v = if1.mispred_cnt;
      endcase
    end
    return v;
  endfunction

  task automatic chk(string n, int unsigned d, int unsigned s, logic [31:0] e);
    exp_t x;
    if (d == D_BOTH) begin
      x = '{name: n, dut: 0, sel: s, exp: e};
      sb.push_back(x);
      x.dut = 1;
      sb.push_back(x);
    end else begin
      x = '{name: n, dut: d, sel: s, exp: e};
      sb.push_back(x);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    lookupF     = 1'b0;
    BpredWriteD = 1'b0;
    mispredictD = 1'b0;
    br_takenD   = 1'b0;
    ghr_snapD   = '0;
    pcD         = '0;
    pcF         = '0;
  endtask

  task automatic mispredict(logic [31:0] pc, logic [HL-1:0] snap, logic taken);
    BpredWriteD = 1'b1;
    mispredictD = 1'b1;
    pcD         = pc;
    ghr_snapD   = snap;
    br_takenD   = taken;
  endtask

  // Monitor: drain every queued expectation at the falling edge.
  initial begin : monitor
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e   = sb.pop_front();
        act = actual(e.dut, e.sel);
        total++;
        if (act !== e.exp) begin
          bad++;
          $display("FAIL %s dut%0d sel%0d: got %h expected %h", e.name, e.dut, e.sel, act, e.exp);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    reset = 1'b0;
    idle();
    tick();
    tick();
    chk("rst_rdy",  D_BOTH, S_RDY,  32'd0);
    chk("rst_pred", D_BOTH, S_PRED, 32'd0);
    chk("rst_ghr",  D_BOTH, S_GHR,  32'd0);
    chk("rst_cnt",  D_BOTH, S_CNT,  32'd0);

    // Traffic during init must be ignored by history, counter and table.
    lookupF     = 1'b1;
    BpredWriteD = 1'b1;
    mispredictD = 1'b1;
    br_takenD   = 1'b1;
    ghr_snapD   = '1;
    pcD         = 32'h40;
    pcF         = 32'h40;
    tick();
    reset = 1'b1;
    for (int k = 1; k <= 1024; k++) begin
      tick();
      if (k == 1024) idle();
      chk("init_rdy", D_BOTH, S_RDY, (k == 1024) ? 32'd1 : 32'd0);
      if (k < 1024) chk("init_pred", D_BOTH, S_PRED, 32'd0);
      if (k == 1023) begin
        chk("init_ghr", D_BOTH, S_GHR, 32'd0);
        chk("init_cnt", D_BOTH, S_CNT, 32'd0);
      end
    end
    chk("run_ghr", D_BOTH, S_GHR, 32'd0);
    chk("run_cnt", D_BOTH, S_CNT, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      case (i)
        0:       pcF = 32'h0000_0000;
        1:       pcF = 32'h0000_0040;
        2:       pcF = 32'h0000_0FFC;
        default: pcF = 32'h1234_5678;
      endcase
      chk("init_weak_taken", D_BOTH, S_PRED, 32'd1);
    end

    // Saturating training on pcD = 0x40 with history 0.
    for (int i = 0; i < 8; i++) begin
      tick();
      pcF         = 32'h40;
      pcD         = 32'h40;
      ghr_snapD   = '0;
      BpredWriteD = 1'b1;
      br_takenD   = T2_DIR[i];
      chk("same_cycle_old", D_BOTH, S_PRED, {31'd0, T2_OLD[i]});
      tick();
      BpredWriteD = 1'b0;
      chk("train_sat", D_BOTH, S_PRED, {31'd0, T2_NEW[i]});
    end

    // Fetch-side history shift, then repair on mispredict.
    tick();
    idle();
    pcF     = 32'h200;
    lookupF = 1'b1;
    chk("shift0_ghr", D_BOTH, S_GHR, 32'h00);
    chk("shift0_pred", D_BOTH, S_PRED, 32'd1);
    tick();
    chk("shift1_ghr", D_BOTH, S_GHR, 32'h01);
    tick();
    chk("shift2_ghr", D_BOTH, S_GHR, 32'h03);
    tick();
    mispredict(32'h300, 8'h01, 1'b0);
    chk("shift3_ghr", D_BOTH, S_GHR, 32'h07);
    chk("pre_mis_cnt", D_BOTH, S_CNT, 32'd0);
    tick();
    idle();
    chk("repair_ghr", D_BOTH, S_GHR, 32'h02);
    chk("repair_cnt", D_BOTH, S_CNT, 32'd1);
    tick();
    mispredictD = 1'b1;
    tick();
    idle();
    chk("unqual_mis_ghr", D_BOTH, S_GHR, 32'h02);
    chk("unqual_mis_cnt", D_BOTH, S_CNT, 32'd1);

    // Gshare indexing: set history to 0x05 and train pcF = 0x100 not taken.
    tick();
    mispredict(32'h3F0, 8'h02, 1'b1);
    tick();
    idle();
    pcF = 32'h100;
    chk("g_ghr5", D_BOTH, S_GHR, 32'h05);
    chk("g_cnt2", D_BOTH, S_CNT, 32'd2);
    chk("g_pred_pre", D_BOTH, S_PRED, 32'd1);
    for (int i = 0; i < 2; i++) begin
      tick();
      pcF         = 32'h100;
      pcD         = 32'h100;
      ghr_snapD   = 8'h05;
      BpredWriteD = 1'b1;
      br_takenD   = 1'b0;
      chk("g_train_old", D_BOTH, S_PRED, (i == 0) ? 32'd1 : 32'd0);
    end
    tick();
    idle();
    pcF = 32'h100;
    chk("g_pred_nt", D_BOTH, S_PRED, 32'd0);
    tick();
    mispredict(32'h3F8, 8'h00, 1'b0);
    tick();
    idle();
    pcF = 32'h100;
    chk("g_ghr0", D_BOTH, S_GHR, 32'h00);
    chk("g_cnt3", D_BOTH, S_CNT, 32'd3);
    chk("bimodal_pc100", 0, S_PRED, 32'd0);
    chk("gshare_pc100_h0", 1, S_PRED, 32'd1);
    tick();
    pcF = 32'h114;
    chk("bimodal_pc114", 0, S_PRED, 32'd1);
    chk("gshare_pc114_h0", 1, S_PRED, 32'd0);

    // Mispredict counter wrap from all-ones.
    tick();
    idle();
    force dut0.r_mispred_cnt = 32'hFFFF_FFFF;
    chk("cnt_forced", 0, S_CNT, 32'hFFFF_FFFF);
    tick();
    release dut0.r_mispred_cnt;
    mispredict(32'h3F8, 8'h00, 1'b0);
    tick();
    idle();
    chk("cnt_wrap", 0, S_CNT, 32'd0);
    chk("cnt_four", 1, S_CNT, 32'd4);

    // Reset from RUN, then again mid-init at entry 500.
    tick();
    reset = 1'b0;
    chk("rerst_rdy",  D_BOTH, S_RDY,  32'd0);
    chk("rerst_cnt",  D_BOTH, S_CNT,  32'd0);
    chk("rerst_ghr",  D_BOTH, S_GHR,  32'd0);
    chk("rerst_pred", D_BOTH, S_PRED, 32'd0);
    tick();
    reset = 1'b1;
    for (int k = 1; k <= 500; k++) begin
      tick();
      if (k == 500) chk("mid_init_rdy", D_BOTH, S_RDY, 32'd0);
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int k = 1; k <= 1024; k++) begin
      tick();
      if (k >= 1023) chk("reinit_rdy", D_BOTH, S_RDY, (k == 1024) ? 32'd1 : 32'd0);
    end
    pcF = 32'h100;
    chk("reinit_pred100", D_BOTH, S_PRED, 32'd1);
    chk("reinit_ghr", D_BOTH, S_GHR, 32'd0);
    chk("reinit_cnt", D_BOTH, S_CNT, 32'd0);
    tick();
    pcF = 32'h40;
    chk("reinit_pred40", D_BOTH, S_PRED, 32'd1);

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard: %0d expectations never checked", sb.size());
    end
    if (total < 100) begin
      bad++;
      $display("FAIL scoreboard: only %0d checks executed", total);
    end
    if (if1.mispred_cnt !== 32'd0) begin
      bad++;
      $display("FAIL final_cnt: got %h expected 0", if1.mispred_cnt);
    end
    if (if0.readyF !== 1'b1) begin
      bad++;
      $display("FAIL final_rdy: got %b expected 1", if0.readyF);
    end
    if (bad != 0) $display("FAIL test: total=%0d bad=%0d", total, bad);
    else          $display("PASS test: total=%0d", total);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
